// File: rtl/pll_reset_seq_if.sv
// ============================================================================
// Module   : pll_reset_seq_if
// Brief    : PLL control/status bundle between the reset sequencer and the
//            PLL / generated-clock consumers.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pll_reset_seq_if;
  logic       lock;
  logic       pll_resetb;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  lock,
    output pll_resetb, sys_rst, ready, fail, retry_cnt, loss_cnt
  );

  modport slave (
    output lock,
    input  pll_resetb, sys_rst, ready, fail, retry_cnt, loss_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pll_reset_seq.sv
// ============================================================================
// Module   : pll_reset_seq
// Brief    : PLL power-up / lock-timeout / loss-of-lock reset sequencer on the
//            reference clock. Optional macro PLL_RESET_SEQ_GLITCH_FILTER_EN
//            filters short lock drops while running.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pll_reset_seq #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RETRY_MAX           = 7,
  parameter int GLITCH_CYCLES       = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pll_reset_seq_if.master       pll_if
);

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int c_MAX_CYC = f_max(f_max(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES),
                                   f_max(LOCK_STABLE_CYCLES, GLITCH_CYCLES));
  localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;

  localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);

  localparam logic [2:0] c_S_PLL_RST = 3'd0;
  localparam logic [2:0] c_S_WAIT    = 3'd1;
  localparam logic [2:0] c_S_STABLE  = 3'd2;
  localparam logic [2:0] c_S_RUN     = 3'd3;
  localparam logic [2:0] c_S_FAIL    = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic [2:0]             r_state, w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]             r_retry, w_retry_sat, w_retry_nxt;
  logic [7:0]             r_loss, w_loss_sat, w_loss_nxt;
  logic                   r_pll_resetb, r_sys_rst, r_ready, r_fail;
  logic                   w_pll_resetb_nxt, w_sys_rst_nxt, w_ready_nxt, w_fail_nxt;
  logic                   w_loss_det, w_retry_evt, w_loss_evt;

  assign w_lock_s    = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_retry_sat = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
  assign w_loss_sat  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;

`ifdef PLL_RESET_SEQ_GLITCH_FILTER_EN
  localparam int                c_GL_W    = $clog2(GLITCH_CYCLES + 1);
  localparam logic [c_GL_W-1:0] c_GL_LAST = c_GL_W'(GLITCH_CYCLES - 1);

  logic [c_GL_W-1:0] r_glitch;

  // Loss only once lock_s has stayed low for GLITCH_CYCLES consecutive samples.
  assign w_loss_det = (r_state == c_S_RUN) && !w_lock_s && (r_glitch == c_GL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch <= '0;
    end else if ((r_state == c_S_RUN) && !w_lock_s && !w_loss_det) begin
      r_glitch <= r_glitch + 1'b1;
    end else begin
      r_glitch <= '0;
    end
  end
`else
  assign w_loss_det = (r_state == c_S_RUN) && !w_lock_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync       <= '0;
      r_state      <= c_S_PLL_RST;
      r_cnt        <= '0;
      r_retry      <= 4'd0;
      r_loss       <= 8'd0;
      r_pll_resetb <= 1'b0;
      r_sys_rst    <= 1'b1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], pll_if.lock};
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_loss       <= w_loss_nxt;
      r_pll_resetb <= w_pll_resetb_nxt;
      r_sys_rst    <= w_sys_rst_nxt;
      r_ready      <= w_ready_nxt;
      r_fail       <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_retry_evt = 1'b0;
    w_loss_evt  = 1'b0;
    case (r_state)
      c_S_PLL_RST: begin
        if (r_cnt == c_RST_LAST) begin
          w_state_nxt = c_S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      c_S_WAIT: begin
        // Lock takes priority over a coincident timeout.
        if (w_lock_s) begin
          w_state_nxt = c_S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_TO_LAST) begin
          w_retry_evt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = (int'(w_retry_sat) > RETRY_MAX) ? c_S_FAIL : c_S_PLL_RST;
        end
      end
      c_S_STABLE: begin
        // The WAIT_LOCK cycle that saw lock_s high counts as the first stable sample.
        if (!w_lock_s) begin
          w_state_nxt = c_S_WAIT;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == c_STB_LAST) begin
          w_state_nxt = c_S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      c_S_RUN: begin
        w_cnt_nxt = '0;
        if (w_loss_det) begin
          w_loss_evt  = 1'b1;
          w_state_nxt = c_S_PLL_RST;
        end
      end
      c_S_FAIL: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = c_S_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_pll_resetb_nxt = (w_state_nxt == c_S_WAIT) || (w_state_nxt == c_S_STABLE) ||
                       (w_state_nxt == c_S_RUN);
    w_sys_rst_nxt    = (w_state_nxt != c_S_RUN);
    w_ready_nxt      = (w_state_nxt == c_S_RUN);
    w_fail_nxt       = (w_state_nxt == c_S_FAIL);
    w_retry_nxt      = r_retry;
    if (w_retry_evt) begin
      w_retry_nxt = w_retry_sat;
    end else if ((r_state != c_S_RUN) && (w_state_nxt == c_S_RUN)) begin
      w_retry_nxt = 4'd0;
    end
    w_loss_nxt = w_loss_evt ? w_loss_sat : r_loss;
  end

  assign pll_if.pll_resetb = r_pll_resetb;
  assign pll_if.sys_rst    = r_sys_rst;
  assign pll_if.ready      = r_ready;
  assign pll_if.fail       = r_fail;
  assign pll_if.retry_cnt  = r_retry;
  assign pll_if.loss_cnt   = r_loss;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
// ============================================================================
// Module   : tb_pll_reset_seq
// Brief    : Directed bench for pll_reset_seq; expected output changes are
//            queued with their cycle stamp and checked by a monitor process.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pll_reset_seq;

  localparam int P_SYNC = 2;
  localparam int P_RST  = 4;
  localparam int P_TO   = 32;
  localparam int P_STB  = 8;
  localparam int P_RMAX = 2;
  localparam int P_GL   = 4;
`ifdef PLL_RESET_SEQ_GLITCH_FILTER_EN
  localparam int DROP = 4;
`else
  localparam int DROP = 1;
`endif
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pll_reset_seq_if u_if ();

  pll_reset_seq #(
    .SYNC_STAGES        (P_SYNC),
    .PLL_RESET_CYCLES   (P_RST),
    .LOCK_TIMEOUT_CYCLES(P_TO),
    .LOCK_STABLE_CYCLES (P_STB),
    .RETRY_MAX          (P_RMAX),
    .GLITCH_CYCLES      (P_GL)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pll_if(u_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] val;
  } exp_t;

  exp_t chg_q[$];
  exp_t snap_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;
  int   m_loss = 0;
  int   k;

  wire [15:0] w_obs = {u_if.pll_resetb, u_if.sys_rst, u_if.ready, u_if.fail,
                       u_if.retry_cnt, u_if.loss_cnt};

  // Field order: pll_resetb, sys_rst, ready, fail, retry_cnt, loss_cnt.
  function automatic logic [15:0] pack(input bit pr, input bit sr, input bit rd,
                                       input bit fl, input int rt, input int ls);
    return {pr, sr, rd, fl, 4'(rt), 8'(ls)};
  endfunction

  task automatic expect_chg(input int at, input logic [15:0] v);
    chg_q.push_back('{at, v});
  endtask

  task automatic expect_snap(input int at, input logic [15:0] v);
    snap_q.push_back('{at, v});
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic reset_dut();
    u_if.lock = 1'b0;
    rst_n     = 1'b0;
    m_loss    = 0;
    expect_snap(cyc + 1, pack(0, 1, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] prev;
  exp_t        e;

  always @(negedge clk) begin
    if (snap_q.size() != 0 && snap_q[0].at == cyc) begin
      e = snap_q.pop_front();
      checks++;
      if (w_obs !== e.val) begin
        errors++;
        $display("FAIL snapshot @%0d: got %h want %h", cyc, w_obs, e.val);
      end
    end
    if (!rst_n) begin
      prev = w_obs;
    end else if (w_obs !== prev) begin
      prev = w_obs;
      checks++;
      if (chg_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected change @%0d: got %h", cyc, w_obs);
      end else begin
        e = chg_q.pop_front();
        if (w_obs !== e.val || cyc != e.at) begin
          errors++;
          $display("FAIL change: got %h @%0d want %h @%0d", w_obs, cyc, e.val, e.at);
        end
      end
    end
    if (done || cyc > LIMIT) begin
      checks++;
      if (!done || chg_q.size() != 0 || snap_q.size() != 0) begin
        errors++;
        $display("FAIL pending: done=%0d changes=%0d snapshots=%0d want 1/0/0",
                 done, chg_q.size(), snap_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    rst_n     = 1'b0;
    u_if.lock = 1'b0;
    @(negedge clk);

    // Normal bring-up: lock 10 cycles after pll_resetb rises, ready 2+8 later.
    reset_dut();
    k = cyc;
    expect_chg(k + 4, pack(1, 1, 0, 0, 0, 0));
    wait_until(k + 14);
    u_if.lock = 1'b1;
    expect_chg(cyc + 10, pack(1, 0, 1, 0, 0, 0));
    wait_until(cyc + 11);

`ifdef PLL_RESET_SEQ_GLITCH_FILTER_EN
    // A drop one cycle shorter than the filter must leave every output alone.
    k = cyc;
    u_if.lock = 1'b0;
    wait_until(k + 3);
    u_if.lock = 1'b1;
    wait_until(k + 20);
`endif

    // Loss-of-lock in RUN, repeated past the loss counter's saturation point.
    for (int i = 0; i < 260; i++) begin
      k = cyc;
      u_if.lock = 1'b0;
      m_loss = (m_loss < 255) ? m_loss + 1 : 255;
      expect_chg(k + 2 + DROP,  pack(0, 1, 0, 0, 0, m_loss));
      expect_chg(k + 6 + DROP,  pack(1, 1, 0, 0, 0, m_loss));
      expect_chg(k + 14 + DROP, pack(1, 0, 1, 0, 0, m_loss));
      wait_until(k + DROP);
      u_if.lock = 1'b1;
      wait_until(k + 15 + DROP);
    end

    // Stability abort: 5 high, 3 low, then high; RUN only after a clean run of 8.
    reset_dut();
    k = cyc;
    expect_chg(k + 4,  pack(1, 1, 0, 0, 0, 0));
    expect_chg(k + 24, pack(1, 0, 1, 0, 0, 0));
    wait_until(k + 6);
    u_if.lock = 1'b1;
    wait_until(k + 11);
    u_if.lock = 1'b0;
    wait_until(k + 14);
    u_if.lock = 1'b1;
    wait_until(k + 26);

    // Asynchronous reset while in STABLE, then a clean restart with lock held.
    reset_dut();
    k = cyc;
    expect_chg(k + 4, pack(1, 1, 0, 0, 0, 0));
    wait_until(k + 6);
    u_if.lock = 1'b1;
    wait_until(k + 11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_snap(cyc, pack(0, 1, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc;
    expect_chg(k + 4,  pack(1, 1, 0, 0, 0, 0));
    expect_chg(k + 12, pack(1, 0, 1, 0, 0, 0));
    wait_until(k + 14);

    // Lock never arrives: three PLL reset pulses, then sticky FAIL.
    reset_dut();
    k = cyc;
    expect_chg(k + 4,   pack(1, 1, 0, 0, 0, 0));
    expect_chg(k + 36,  pack(0, 1, 0, 0, 1, 0));
    expect_chg(k + 40,  pack(1, 1, 0, 0, 1, 0));
    expect_chg(k + 72,  pack(0, 1, 0, 0, 2, 0));
    expect_chg(k + 76,  pack(1, 1, 0, 0, 2, 0));
    expect_chg(k + 108, pack(0, 1, 0, 1, 3, 0));
    wait_until(k + 150);
    u_if.lock = 1'b1;
    wait_until(k + 200);
    expect_snap(cyc + 1, pack(0, 1, 0, 1, 3, 0));
    wait_until(k + 202);
    done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Consumer-side counterpart of the iCE40 PLL clock generator.
- Runs on the free-running reference clock. Drives the PLL RESETB input and watches the PLL LOCK output.
- Produces a clean system reset request and ready/fail status for the generated-clock domain.
- Handles power-up sequencing, lock timeout with bounded retry, and loss-of-lock recovery.

Parameters:
- SYNC_STAGES, 2, flops in the lock synchronizer (min 2).
- PLL_RESET_CYCLES, 16, cycles pll_resetb is held low per PLL reset attempt.
- LOCK_TIMEOUT_CYCLES, 65536, max cycles to wait for synchronized lock after PLL reset release.
- LOCK_STABLE_CYCLES, 1024, consecutive lock-high cycles required before release.
- RETRY_MAX, 7, PLL reset attempts allowed before FAIL.
- GLITCH_CYCLES, 4, lock-low persistence needed to declare loss (optional feature only).

Ports:
- clk  in  1  reference clock, free-running, independent of PLL
- rst_n  in  1  asynchronous active-low reset
- lock  in  1  PLL LOCK, asynchronous to clk
- pll_resetb  out  1  to PLL RESETB, active-low
- sys_rst  out  1  active-high system reset request; consumer re-synchronizes into the PLL clock domain
- ready  out  1  high while PLL locked and system released
- fail  out  1  sticky; retries exhausted
- retry_cnt  out  4  PLL reset attempts since rst_n (saturating at 15)
- loss_cnt  out  8  loss-of-lock events in RUN (saturating at 255)

Behaviour:
- Reset: asynchronous on rst_n low; all outputs are registered.
  - Reset values: pll_resetb=0, sys_rst=1, ready=0, fail=0, retry_cnt=0, loss_cnt=0, state=PLL_RST, cycle counter=0, synchronizer=0.
- Lock sync: lock passes through SYNC_STAGES flops; lock_s is the last stage. All FSM decisions use lock_s only.
- States:
  - PLL_RST: pll_resetb=0, sys_rst=1. Count PLL_RESET_CYCLES, then go to WAIT_LOCK and clear the counter. pll_resetb rises on the cycle of entry to WAIT_LOCK.
  - WAIT_LOCK: pll_resetb=1, sys_rst=1. Counter runs.
    - lock_s=1: go to STABLE, clear counter.
    - Counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0: increment retry_cnt.
      - New retry_cnt > RETRY_MAX: go to FAIL.
      - Otherwise: go to PLL_RST.
  - STABLE: sys_rst=1.
    - lock_s=0: back to WAIT_LOCK, counter cleared. This is not a timeout and not a loss.
    - Counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1: go to RUN.
  - RUN: sys_rst=0, ready=1. Both take effect in the first RUN cycle (registered, asserted on the transition edge).
    - Declared loss: in the same cycle ready and sys_rst return to 0/1, loss_cnt increments, go to PLL_RST.
    - retry_cnt is not incremented by a loss. Retry budget is per bring-up.
    - retry_cnt is cleared on entry to RUN.
  - FAIL: pll_resetb=0, sys_rst=1, ready=0, fail=1. Terminal until rst_n.
- Counters:
  - The cycle counter is $clog2 of the largest cycle parameter, plus 1 bit. It never wraps within a state.
  - retry_cnt and loss_cnt saturate; they do not wrap.
- Simultaneous events: in WAIT_LOCK, if lock_s rises in the timeout cycle, lock wins (go to STABLE).
- Latency:
  - lock rising to lock_s: SYNC_STAGES cycles.
  - lock_s high to ready: LOCK_STABLE_CYCLES cycles.
  - Loss declared to sys_rst=1: 1 cycle.
- Reset mid-operation: rst_n low in any state returns to reset values immediately; counters are cleared.

Optional Feature:
- Macro: PLL_RESET_SEQ_GLITCH_FILTER_EN.
- Defined:
  - In RUN, loss is declared only after lock_s has been low for GLITCH_CYCLES consecutive cycles.
  - A shorter low pulse is ignored. ready stays 1 and loss_cnt is unchanged.
  - The glitch counter clears when lock_s=1.
- Undefined:
  - A single cycle of lock_s=0 in RUN declares loss.
  - GLITCH_CYCLES is unused.

Test Plan:
All tests use PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, RETRY_MAX=2, SYNC_STAGES=2.
1. Normal bring-up: release rst_n; lock rises 10 cycles after pll_resetb rises -> ready=1 exactly 2+8 cycles after the lock edge; sys_rst=0; retry_cnt=0.
2. Stability abort: lock high 5 cycles, low 3, then high -> no RUN until 8 consecutive synchronized highs; loss_cnt=0.
3. Timeout and fail: lock held 0 -> three PLL_RST pulses of 4 cycles each; then fail=1, retry_cnt=3, pll_resetb=0, sys_rst=1, held indefinitely.
4. Loss in RUN:
   - Macro undefined: 1-cycle lock drop -> sys_rst=1 two cycles later, loss_cnt=1, new PLL_RST pulse, relock -> ready=1.
   - Macro defined (GLITCH_CYCLES=4): 3-cycle drop is ignored; 4-cycle drop gives loss_cnt=1.
5. Async reset mid-STABLE: assert rst_n low between clock edges -> outputs return to reset values without a clock edge; counters restart from 0 after release.
6. Saturation: force 260 loss events -> loss_cnt holds 255.
